// File: rtl/cpu_mem_arbiter.sv
// Round-robin arbiter sharing one burst memory port between icache fills and
// dcache fills/write-backs; the grant is held for a whole BURST_LEN-word burst.
module cpu_mem_arbiter #(
  parameter int unsigned BURST_LEN = 8,
  parameter int unsigned ADDR_W    = 32
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              ic_request_i,
  input  logic [ADDR_W-1:0] ic_addr_i,
  output logic [31:0]       ic_rdata_o,
  output logic              ic_rvalid_o,
  output logic              ic_done_o,
  input  logic              dc_request_i,
  input  logic [ADDR_W-1:0] dc_addr_i,
  input  logic              dc_write_i,
  input  logic [31:0]       dc_wdata_i,
  output logic              dc_wready_o,
  output logic [31:0]       dc_rdata_o,
  output logic              dc_rvalid_o,
  output logic              dc_done_o,
  output logic              mem_request_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_write_o,
  input  logic              mem_ack_i,
  output logic [31:0]       mem_wdata_o,
  input  logic              mem_wready_i,
  input  logic [31:0]       mem_rdata_i,
  input  logic              mem_rvalid_i
);

  localparam int unsigned CNT_W = $clog2(BURST_LEN) + 1;

  typedef enum logic [1:0] {S_IDLE, S_CMD, S_DATA, S_DONE} state_e;
  typedef enum logic {OWN_IC, OWN_DC} owner_e;

  state_e              state_q;
  owner_e              owner_q;
  owner_e              last_q;
  logic [ADDR_W-1:0]   addr_q;
  logic                write_q;
  logic                req_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                ic_done_q;
  logic                dc_done_q;

  logic grant_ic_c;
  logic data_rd_c;
  logic data_wr_c;
  logic beat_c;

  // Icache wins when alone or when dcache held the previous grant.
  assign grant_ic_c = ic_request_i && (!dc_request_i || (last_q == OWN_DC));

  assign data_rd_c = (state_q == S_DATA) && !write_q;
  assign data_wr_c = (state_q == S_DATA) && write_q;
  assign beat_c    = data_wr_c ? mem_wready_i : (data_rd_c && mem_rvalid_i);

  // Read data is a gated pass-through so idle and non-owner ports stay at zero.
  always_comb begin
    ic_rvalid_o = 1'b0;
    ic_rdata_o  = '0;
    dc_rvalid_o = 1'b0;
    dc_rdata_o  = '0;
    dc_wready_o = 1'b0;
    mem_wdata_o = '0;
    if (data_rd_c && mem_rvalid_i) begin
      if (owner_q == OWN_IC) begin
        ic_rvalid_o = 1'b1;
        ic_rdata_o  = mem_rdata_i;
      end else begin
        dc_rvalid_o = 1'b1;
        dc_rdata_o  = mem_rdata_i;
      end
    end
    if (data_wr_c) begin
      dc_wready_o = mem_wready_i;
      mem_wdata_o = dc_wdata_i;
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q   <= S_IDLE;
      owner_q   <= OWN_IC;
      last_q    <= OWN_DC;
      addr_q    <= '0;
      write_q   <= 1'b0;
      req_q     <= 1'b0;
      cnt_q     <= '0;
      ic_done_q <= 1'b0;
      dc_done_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (ic_request_i || dc_request_i) begin
            if (grant_ic_c) begin
              owner_q <= OWN_IC;
              addr_q  <= ic_addr_i;
              write_q <= 1'b0;
            end else begin
              owner_q <= OWN_DC;
              addr_q  <= dc_addr_i;
              write_q <= dc_write_i;
            end
            req_q   <= 1'b1;
            state_q <= S_CMD;
          end
        end
        S_CMD: begin
          if (mem_ack_i) begin
            req_q   <= 1'b0;
            cnt_q   <= '0;
            state_q <= S_DATA;
          end
        end
        S_DATA: begin
          if (beat_c) begin
            cnt_q <= cnt_q + CNT_W'(1);
            // Last beat of the burst: raise the owner's done for the DONE cycle.
            if (cnt_q == CNT_W'(BURST_LEN - 1)) begin
              state_q <= S_DONE;
              if (owner_q == OWN_IC) ic_done_q <= 1'b1;
              else                   dc_done_q <= 1'b1;
            end
          end
        end
        S_DONE: begin
          ic_done_q <= 1'b0;
          dc_done_q <= 1'b0;
          last_q    <= owner_q;
          state_q   <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign mem_request_o = req_q;
  assign mem_addr_o    = addr_q;
  assign mem_write_o   = write_q;
  assign ic_done_o     = ic_done_q;
  assign dc_done_o     = dc_done_q;

endmodule
